// File: rtl/series_player.sv
// series_player: sequences notes from a fixed 4-song ROM for a frequency divider,
// with live keypad override.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   en                - global enable; low freezes sequencing and mutes outputs
//   start, stop       - begin a song / abort playback (stop wins)
//   loop, song_sel    - repeat flag and song number, latched on accepted start
//   key_in            - live keypad code (0 = no key)
//   keycode           - keypad code to the divider (combinational bypass of key_in)
//   sound_series      - sequenced note to the divider (0 = silent)
//   busy              - song in progress (LOAD/PLAY/GAP)
//   done              - one-cycle pulse at natural end of song
module series_player #(
  parameter int unsigned BEAT_CYCLES = 2500000,
  parameter int unsigned GAP_CYCLES  = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic [1:0] song_sel,
  input  logic [3:0] key_in,
  output logic [3:0] keycode,
  output logic [3:0] sound_series,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned SONG_W = 2;
  localparam int unsigned BEAT_W = 2;
  localparam int unsigned CNT_W  = $clog2(4 * BEAT_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(7);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t              state_q, state_n;
  logic [STEP_W-1:0]   step_q, step_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [SONG_W-1:0]   song_q, song_n;
  logic                loop_q, loop_n;
  logic [NOTE_W-1:0]   note_q, note_n;
  logic [BEAT_W-1:0]   beats_q, beats_n;
  logic                done_q, done_n;

  logic [CNT_W-1:0]    play_last;
  logic [STEP_W-1:0]   step_inc;
  logic [5:0]          first_entry;
  logic [5:0]          next_entry;

  // Song ROM: {note[3:0], beats_minus_1[1:0]}; notes 13..15 mark end of song.
  function automatic logic [5:0] rom(input logic [SONG_W-1:0] song,
                                     input logic [STEP_W-1:0] step);
    logic [5:0] e;
    e = 6'h00;
    case ({song, step})
      {2'd0, 3'd0}: e = {4'd1,  2'd0};
      {2'd0, 3'd1}: e = {4'd3,  2'd0};
      {2'd0, 3'd2}: e = {4'd5,  2'd0};
      {2'd0, 3'd3}: e = {4'd6,  2'd0};
      {2'd0, 3'd4}: e = {4'd8,  2'd0};
      {2'd0, 3'd5}: e = {4'd10, 2'd0};
      {2'd0, 3'd6}: e = {4'd12, 2'd0};
      {2'd0, 3'd7}: e = {4'd0,  2'd0};
      {2'd1, 3'd0}: e = {4'd12, 2'd1};
      {2'd1, 3'd1}: e = {4'd10, 2'd1};
      {2'd1, 3'd2}: e = {4'd8,  2'd1};
      {2'd1, 3'd3}: e = {4'd6,  2'd1};
      {2'd1, 3'd4}: e = {4'd5,  2'd1};
      {2'd1, 3'd5}: e = {4'd3,  2'd1};
      {2'd1, 3'd6}: e = {4'd1,  2'd1};
      {2'd1, 3'd7}: e = {4'd15, 2'd1};
      {2'd2, 3'd0}: e = {4'd15, 2'd0};
      {2'd3, 3'd0}: e = {4'd15, 2'd0};
      default:      e = 6'h00;
    endcase
    return e;
  endfunction

  function automatic logic is_end(input logic [5:0] e);
    return e[5:2] >= NOTE_W'(13);
  endfunction

  // Last PLAY count of the current step: beats*BEAT_CYCLES - GAP_CYCLES - 1.
  assign play_last   = CNT_W'((32'(beats_q) + 32'd1) * BEAT_CYCLES - GAP_CYCLES - 32'd1);
  assign step_inc    = step_q + STEP_W'(1);
  assign first_entry = rom(song_q, '0);
  assign next_entry  = rom(song_q, step_inc);

  // State and sequencing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      song_q  <= '0;
      loop_q  <= 1'b0;
      note_q  <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      step_q  <= step_n;
      cnt_q   <= cnt_n;
      song_q  <= song_n;
      loop_q  <= loop_n;
      note_q  <= note_n;
      beats_q <= beats_n;
      done_q  <= done_n;
    end
  end

  // Next-state logic; with en low every register holds its value.
  always_comb begin
    state_n = state_q;
    step_n  = step_q;
    cnt_n   = cnt_q;
    song_n  = song_q;
    loop_n  = loop_q;
    note_n  = note_q;
    beats_n = beats_q;
    done_n  = 1'b0;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            song_n  = song_sel;
            loop_n  = loop;
            step_n  = '0;
            cnt_n   = '0;
            state_n = LOAD;
          end
        end
        LOAD: begin
          if (stop) begin
            state_n = IDLE;
          end else if (is_end(first_entry)) begin
            // Empty song: finish (or spin through LOAD when looping) without PLAY.
            if (!loop_q) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end else begin
            note_n  = first_entry[5:2];
            beats_n = first_entry[1:0];
            cnt_n   = '0;
            state_n = PLAY;
          end
        end
        PLAY: begin
          if (stop) begin
            state_n = IDLE;
          end else if (cnt_q == play_last) begin
            cnt_n   = '0;
            state_n = GAP;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (stop) begin
            state_n = IDLE;
          end else if (cnt_q == GAP_LAST) begin
            cnt_n = '0;
            if (step_q == LAST_STEP || is_end(next_entry)) begin
              step_n = '0;
              if (loop_q) begin
                state_n = LOAD;
              end else begin
                done_n  = 1'b1;
                state_n = IDLE;
              end
            end else begin
              // Next step starts immediately so each step spans beats*BEAT_CYCLES.
              step_n  = step_inc;
              note_n  = next_entry[5:2];
              beats_n = next_entry[1:0];
              state_n = PLAY;
            end
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output decode; a pressed key takes priority and mutes the sequence.
  assign busy         = (state_q != IDLE);
  assign done         = done_q & en;
  assign keycode      = en ? key_in : '0;
  assign sound_series = (en && (key_in == '0) && (state_q == PLAY)) ? note_q : '0;

endmodule

// File: tb/tb_series_player.sv
// Directed bench for series_player with BEAT_CYCLES=8, GAP_CYCLES=2.
// Cycle 0 is the cycle in which start is driven; LOAD occupies cycle 1.
module tb_series_player;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start;
  logic       stop;
  logic       loop;
  logic [1:0] song_sel;
  logic [3:0] key_in;
  logic [3:0] keycode;
  logic [3:0] sound_series;
  logic       busy;
  logic       done;

  int vectors = 0;
  int errors  = 0;

  logic [3:0] notes0 [8] = '{4'd1, 4'd3, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd0};
  logic [3:0] notes1 [7] = '{4'd12, 4'd10, 4'd8, 4'd6, 4'd5, 4'd3, 4'd1};

  series_player #(.BEAT_CYCLES(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .loop(loop),
    .song_sel(song_sel), .key_in(key_in), .keycode(keycode),
    .sound_series(sound_series), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 1'b1; stop = 1'b0; loop = 1'b0;
    song_sel = 2'd0; key_in = 4'd0;
    next_cycle();
    next_cycle();
    start = 1'b0;
    #1;
    vectors++;
    if ({busy, done, sound_series, keycode} !== 10'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b sound=%0d key=%0d, expected all 0",
               busy, done, sound_series, keycode);
    end
    rst = 1'b0;
    next_cycle();
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_song0();
    logic [3:0] es;
    logic       eb, ed;
    int         k, off;
    song_sel = 2'd0; loop = 1'b0; start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      if (c > 1) next_cycle();
      #1;
      eb = (c < 66);
      ed = (c == 66);
      es = 4'd0;
      if (c >= 2 && c < 66) begin
        k   = (c - 2) / 8;
        off = (c - 2) % 8;
        if (off < 6) es = notes0[k];
      end
      vectors++;
      if ({busy, done, sound_series} !== {eb, ed, es}) begin
        errors++;
        $display("FAIL song0 cycle %0d: busy=%b done=%b sound=%0d, expected %b %b %0d",
                 c, busy, done, sound_series, eb, ed, es);
      end
    end
  endtask

  task automatic test_song1_loop();
    logic [3:0] es;
    int         k, off;
    song_sel = 2'd1; loop = 1'b1; start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= 121; c++) begin
      if (c > 1) next_cycle();
      #1;
      es = 4'd0;
      if (c >= 2 && c <= 113) begin
        k   = (c - 2) / 16;
        off = (c - 2) % 16;
        if (off < 14) es = notes1[k];
      end else if (c >= 115) begin
        es = 4'd12;
      end
      vectors++;
      if ({busy, done, sound_series} !== {1'b1, 1'b0, es}) begin
        errors++;
        $display("FAIL song1_loop cycle %0d: busy=%b done=%b sound=%0d, expected 1 0 %0d",
                 c, busy, done, sound_series, es);
      end
    end
    // Stop while in PLAY
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    #1;
    vectors++;
    if ({busy, done, sound_series} !== 6'd0) begin
      errors++;
      $display("FAIL stop_play: busy=%b done=%b sound=%0d, expected 0 0 0",
               busy, done, sound_series);
    end
    next_cycle();
    #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL stop_nodone: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_key();
    logic [3:0] es, ek;
    song_sel = 2'd0; loop = 1'b0; start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 2; c <= 15; c++) begin
      next_cycle();
      key_in = (c >= 3 && c <= 5) ? 4'd5 : 4'd0;
      #1;
      ek = key_in;
      if (ek != 4'd0)   es = 4'd0;
      else if (c <= 7)  es = 4'd1;
      else if (c <= 9)  es = 4'd0;
      else              es = 4'd3;
      vectors++;
      if ({keycode, sound_series} !== {ek, es}) begin
        errors++;
        $display("FAIL key cycle %0d: keycode=%0d sound=%0d, expected %0d %0d",
                 c, keycode, sound_series, ek, es);
      end
    end
    key_in = 4'd0;
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
  endtask

  task automatic test_song2();
    song_sel = 2'd2; loop = 1'b0; start = 1'b1;
    next_cycle();
    start = 1'b0;
    #1;
    vectors++;
    if ({busy, done, sound_series} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL song2_load: busy=%b done=%b sound=%0d, expected 1 0 0",
               busy, done, sound_series);
    end
    next_cycle();
    #1;
    vectors++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL song2_done: busy=%b done=%b, expected 0 1", busy, done);
    end
    next_cycle();
    #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL song2_idle: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    // start and stop together from IDLE
    start = 1'b1; stop = 1'b1; song_sel = 2'd0;
    next_cycle();
    start = 1'b0; stop = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_stop: busy=%b, expected 0", busy);
    end
    next_cycle();
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_hold: busy=%b, expected 0", busy);
    end
    // start while busy must not switch songs
    song_sel = 2'd0; loop = 1'b0; start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      next_cycle();
      if (c == 4) begin
        start = 1'b1; song_sel = 2'd1; loop = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (c == 5 || c == 10) begin
        vectors++;
        if (sound_series !== ((c == 5) ? 4'd1 : 4'd3)) begin
          errors++;
          $display("FAIL start_busy cycle %0d: sound=%0d, expected %0d",
                   c, sound_series, (c == 5) ? 1 : 3);
        end
      end
    end
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
  endtask

  task automatic test_enable_reset();
    logic [3:0] es;
    song_sel = 2'd0; loop = 1'b0; start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 2; c <= 15; c++) begin
      next_cycle();
      en     = !(c >= 4 && c <= 8);
      key_in = (c == 6) ? 4'd7 : 4'd0;
      #1;
      if (!en)          es = 4'd0;
      else if (c <= 12) es = 4'd1;
      else if (c <= 14) es = 4'd0;
      else              es = 4'd3;
      vectors++;
      if ({keycode, sound_series, done} !== {4'd0, es, 1'b0}) begin
        errors++;
        $display("FAIL enable cycle %0d: keycode=%0d sound=%0d done=%b, expected 0 %0d 0",
                 c, keycode, sound_series, done, es);
      end
    end
    key_in = 4'd0;
    en = 1'b1;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    vectors++;
    if ({busy, done, sound_series, keycode} !== 10'd0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b sound=%0d key=%0d, expected all 0",
               busy, done, sound_series, keycode);
    end
    next_cycle();
    #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL rst_nodone: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_song0();
    next_cycle();
    test_song1_loop();
    next_cycle();
    test_key();
    next_cycle();
    test_song2();
    next_cycle();
    test_back_to_back();
    next_cycle();
    test_enable_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
